// File: rtl/img_pkg.sv
// Shared pixel-pipeline constants, sideband struct and arithmetic helpers.
// Latency: none; declarations and pure functions only.
// Backpressure: none; users consume one pixel per clock.
package img_pkg;

  localparam int PIX_W   = 24;
  localparam int COORD_W = 12;
  localparam int GRAY_W  = 8;
  localparam int GRAD_W  = 11;
  localparam int H_DISP  = 640;
  localparam int V_DISP  = 480;

  localparam int GW_R = 77;
  localparam int GW_G = 150;
  localparam int GW_B = 29;

  // Sync/valid/coordinate sideband that travels alongside each pixel
  typedef struct packed {
    logic               de;
    logic               hsync;
    logic               vsync;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } ctl_t;

  // Weights sum to 256, so the sum tops out at 255*256 and fits 16 bits
  function automatic logic [GRAY_W-1:0] rgb2gray(input logic [PIX_W-1:0] pix);
    logic [15:0] acc;
    acc = 16'(GW_R) * 16'(pix[23:16])
        + 16'(GW_G) * 16'(pix[15:8])
        + 16'(GW_B) * 16'(pix[7:0]);
    return GRAY_W'(acc >> 8);
  endfunction

  // Zero-extend a gray sample into the signed gradient width
  function automatic logic signed [GRAD_W-1:0] gext(input logic [GRAY_W-1:0] v);
    return signed'(GRAD_W'(v));
  endfunction

endpackage

// File: rtl/line_buf.sv
// One video line of gray samples: simple dual-port RAM, one write and one read port.
// Latency: read data is registered, valid the cycle after rd_addr.
// Backpressure: none; write when wr_en, read every cycle.
module line_buf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not reset; border masking hides stale lines
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sobel_edge_det.sv
// Sobel edge detector on the gray-converted video stream; flags the 3x3 window centre.
// Latency: fixed 4 clocks from in_* to out_* for data, syncs and coordinates.
// Backpressure: none; accepts one pixel per clock, blanking gaps pass straight through.
module sobel_edge_det #(
  parameter int          H_DISP = img_pkg::H_DISP,
  parameter int          V_DISP = img_pkg::V_DISP,
  parameter logic [10:0] THRESH = 11'd150
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic        in_de,
  input  logic [23:0] in_data,
  input  logic [11:0] in_x,
  input  logic [11:0] in_y,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        out_de,
  output logic        out_edge,
  output logic [23:0] out_data,
  output logic [11:0] out_x,
  output logic [11:0] out_y
);
  import img_pkg::*;

  localparam int AW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
  localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(H_DISP - 1);
  localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(V_DISP - 1);

  ctl_t                     in_ctl, s1_ctl, s2_ctl, s3_ctl, s4_ctl;
  logic [GRAY_W-1:0]        s1_gray, s2_gray;
  logic [COORD_W-1:0]       col_cnt, row_cnt, s2_col, s2_row;
  logic                     de_fall, vs_fall;
  logic [GRAY_W-1:0]        b0_q, b1_q;
  logic [2:0][GRAY_W-1:0]   col_l, col_m, col_r;
  logic signed [GRAD_W-1:0] gx_c, gy_c, s3_gx, s3_gy;
  logic                     s3_mask;
  logic [GRAD_W-1:0]        abs_x, abs_y, mag_c;
  logic                     edge_q;

  assign in_ctl = '{de: in_de, hsync: in_hsync, vsync: in_vsync, x: in_x, y: in_y};

  // Stage-2 vs stage-1 sideband gives the previous-cycle values for edge detection
  assign de_fall = s2_ctl.de & ~s1_ctl.de;
  assign vs_fall = s2_ctl.vsync & ~s1_ctl.vsync;

  // Sideband delay line plus gray conversion and stage-2 copies of position/gray
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ctl  <= '0;
      s2_ctl  <= '0;
      s3_ctl  <= '0;
      s4_ctl  <= '0;
      s1_gray <= '0;
      s2_gray <= '0;
      s2_col  <= '0;
      s2_row  <= '0;
    end else begin
      s1_ctl  <= in_ctl;
      s2_ctl  <= s1_ctl;
      s3_ctl  <= s2_ctl;
      s4_ctl  <= s3_ctl;
      s1_gray <= rgb2gray(in_data);
      s2_gray <= s1_gray;
      s2_col  <= col_cnt;
      s2_row  <= row_cnt;
    end
  end

  // Column/row position of the pixel currently held in stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      if (s1_ctl.de)    col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
      else if (de_fall) col_cnt <= '0;
      if (vs_fall)                           row_cnt <= '0;
      else if (de_fall && row_cnt != ROW_LAST) row_cnt <= row_cnt + 1'b1;
    end
  end

  // buf0 holds the previous line, buf1 the one before; each pixel pushes its column down
  line_buf #(.DEPTH(H_DISP), .WIDTH(GRAY_W)) u_buf0 (
    .clk     (clk),
    .wr_en   (s2_ctl.de),
    .wr_addr (s2_col[AW-1:0]),
    .wr_data (s2_gray),
    .rd_addr (col_cnt[AW-1:0]),
    .rd_data (b0_q)
  );

  line_buf #(.DEPTH(H_DISP), .WIDTH(GRAY_W)) u_buf1 (
    .clk     (clk),
    .wr_en   (s2_ctl.de),
    .wr_addr (s2_col[AW-1:0]),
    .wr_data (b0_q),
    .rd_addr (col_cnt[AW-1:0]),
    .rd_data (b1_q)
  );

  // Newest window column straight from the RAM outputs: [2]=top, [1]=middle, [0]=bottom
  assign col_r = {b1_q, b0_q, s2_gray};

  // Shift the two older window columns only on valid pixels so blanking leaves them intact
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_l <= '0;
      col_m <= '0;
    end else if (s2_ctl.de) begin
      col_l <= col_m;
      col_m <= col_r;
    end
  end

  assign gx_c = (gext(col_r[2]) + (gext(col_r[1]) <<< 1) + gext(col_r[0]))
              - (gext(col_l[2]) + (gext(col_l[1]) <<< 1) + gext(col_l[0]));
  assign gy_c = (gext(col_l[0]) + (gext(col_m[0]) <<< 1) + gext(col_r[0]))
              - (gext(col_l[2]) + (gext(col_m[2]) <<< 1) + gext(col_r[2]));

  // Gradients plus a border mask when the window reaches past the line or frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_gx   <= '0;
      s3_gy   <= '0;
      s3_mask <= 1'b0;
    end else begin
      s3_gx   <= gx_c;
      s3_gy   <= gy_c;
      s3_mask <= (s2_col < COORD_W'(2)) | (s2_row < COORD_W'(2));
    end
  end

  assign abs_x = s3_gx[GRAD_W-1] ? $unsigned(-s3_gx) : $unsigned(s3_gx);
  assign abs_y = s3_gy[GRAD_W-1] ? $unsigned(-s3_gy) : $unsigned(s3_gy);
  assign mag_c = abs_x + abs_y;

  // Threshold the magnitude; the flag is only ever set alongside a valid pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_q <= 1'b0;
    else        edge_q <= s3_ctl.de & ~s3_mask & (mag_c >= THRESH);
  end

  assign out_de    = s4_ctl.de;
  assign out_hsync = s4_ctl.hsync;
  assign out_vsync = s4_ctl.vsync;
  assign out_x     = s4_ctl.x;
  assign out_y     = s4_ctl.y;
  assign out_edge  = edge_q;
  assign out_data  = {PIX_W{edge_q}};

endmodule

// File: tb/tb_sobel_edge_det.sv
// Scoreboard bench for sobel_edge_det on a small 8x6 frame with threshold 100.
// Stimulus pushes expected pixels; a negedge monitor pops and compares on out_de.
// Sync outputs are compared against the inputs recorded four cycles earlier.
module tb_sobel_edge_det;

  localparam int          TB_H  = 8;
  localparam int          TB_V  = 6;
  localparam logic [10:0] TB_TH = 11'd100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_hsync, in_vsync, in_de;
  logic [23:0] in_data;
  logic [11:0] in_x, in_y;
  logic        out_hsync, out_vsync, out_de, out_edge;
  logic [23:0] out_data;
  logic [11:0] out_x, out_y;

  always #5 clk = ~clk;

  sobel_edge_det #(.H_DISP(TB_H), .V_DISP(TB_V), .THRESH(TB_TH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_hsync  (in_hsync),
    .in_vsync  (in_vsync),
    .in_de     (in_de),
    .in_data   (in_data),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_hsync (out_hsync),
    .out_vsync (out_vsync),
    .out_de    (out_de),
    .out_edge  (out_edge),
    .out_data  (out_data),
    .out_x     (out_x),
    .out_y     (out_y)
  );

  typedef struct {
    int          stamp;
    logic [11:0] x;
    logic [11:0] y;
    logic        edge_f;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          sync_ok = 32'h7fff_ffff;
  int          mode = 0;
  logic        hs_hist [8];
  logic        vs_hist [8];
  logic [23:0] img [TB_V][TB_H];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int gray_of(input logic [23:0] px);
    return (77 * int'(px[23:16]) + 150 * int'(px[15:8]) + 29 * int'(px[7:0])) >>> 8;
  endfunction

  // Expected edge flag of the window whose newest pixel is (x, y)
  function automatic logic model_edge(input int x, input int y, input int rowc);
    int p [3][3];
    int gx, gy, mag;
    if (x < 2 || rowc < 2) return 1'b0;
    case (mode)
      0: return 1'b0;                       // flat grey
      1: return (x == 4 || x == 5);         // vertical step at column 4, |Gx| = 1020
      2: return (y == 3 || y == 4);         // 0 -> gray 25 at row 3, |Gy| = 100
      3: return 1'b0;                       // 0 -> gray 24 at row 3, |Gy| = 96
      default: begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            p[r][c] = gray_of(img[y - 2 + r][x - 2 + c]);
        gx  = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
        gy  = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return mag >= int'(TB_TH);
      end
    endcase
  endfunction

  task automatic drive(input logic de, input logic hs, input logic vs,
                       input int x, input int y, input logic [23:0] d);
    @(posedge clk);
    #1;
    in_de    = de;
    in_hsync = hs;
    in_vsync = vs;
    in_x     = 12'(x);
    in_y     = 12'(y);
    in_data  = d;
    hs_hist[3'(cyc % 8)] = hs;
    vs_hist[3'(cyc % 8)] = vs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b1, 0, 0, 24'h0);
  endtask

  task automatic push_exp(input int x, input int y, input logic e);
    exp_t it;
    it.stamp  = cyc;
    it.x      = 12'(x);
    it.y      = 12'(y);
    it.edge_f = e;
    exp_q.push_back(it);
  endtask

  // One active line followed by a single-cycle de gap with hsync asserted
  task automatic send_line(input int y, input int rowc);
    for (int x = 0; x < TB_H; x++) begin
      drive(1'b1, 1'b1, 1'b1, x, y, img[y][x]);
      push_exp(x, y, model_edge(x, y, rowc));
    end
    drive(1'b0, 1'b0, 1'b1, 0, y, 24'h0);
  endtask

  task automatic vsync_pulse();
    drive(1'b0, 1'b1, 1'b0, 0, 0, 24'h0);
    drive(1'b0, 1'b1, 1'b0, 0, 0, 24'h0);
    idle(2);
  endtask

  task automatic fill(input int kind);
    mode = kind;
    for (int y = 0; y < TB_V; y++)
      for (int x = 0; x < TB_H; x++)
        case (kind)
          0:       img[y][x] = 24'h808080;
          1:       img[y][x] = (x < 4) ? 24'h000000 : 24'hFFFFFF;
          2:       img[y][x] = (y < 3) ? 24'h000000 : 24'h191919;
          3:       img[y][x] = (y < 3) ? 24'h000000 : 24'h181818;
          default: img[y][x] = 24'($urandom);
        endcase
  endtask

  task automatic run_frame(input int kind);
    fill(kind);
    vsync_pulse();
    for (int y = 0; y < TB_V; y++) send_line(y, y);
    idle(3);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_de"},    32'(out_de),    32'h0);
    check({tag, "_edge"},  32'(out_edge),  32'h0);
    check({tag, "_data"},  32'(out_data),  32'h0);
    check({tag, "_x"},     32'(out_x),     32'h0);
    check({tag, "_y"},     32'(out_y),     32'h0);
    check({tag, "_hsync"}, 32'(out_hsync), 32'h0);
    check({tag, "_vsync"}, 32'(out_vsync), 32'h0);
  endtask

  // Monitor: pop the scoreboard on every output pixel, police idle cycles and syncs
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_de) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: out_x=%0d out_y=%0d with nothing outstanding", out_x, out_y);
        end else begin
          mon_e = exp_q.pop_front();
          check("latency", 32'(cyc - mon_e.stamp), 32'd4);
          check("out_x",    32'(out_x),    32'(mon_e.x));
          check("out_y",    32'(out_y),    32'(mon_e.y));
          check("out_edge", 32'(out_edge), 32'(mon_e.edge_f));
          check("out_data", 32'(out_data), mon_e.edge_f ? 32'hFFFFFF : 32'h0);
        end
      end else begin
        check("idle_edge", 32'(out_edge), 32'h0);
        check("idle_data", 32'(out_data), 32'h0);
      end
      if (cyc >= sync_ok) begin
        check("out_hsync", 32'(out_hsync), 32'(hs_hist[3'((cyc - 4) % 8)]));
        check("out_vsync", 32'(out_vsync), 32'(vs_hist[3'((cyc - 4) % 8)]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    in_de    = 1'b0;
    in_hsync = 1'b1;
    in_vsync = 1'b1;
    in_data  = 24'h0;
    in_x     = 12'h0;
    in_y     = 12'h0;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    rst_n   = 1'b1;
    sync_ok = cyc + 6;

    // Lone pixel at (5,7): appears 4 cycles later, masked since no rows precede it
    idle(2);
    drive(1'b1, 1'b1, 1'b1, 5, 7, 24'h123456);
    push_exp(5, 7, 1'b0);
    idle(6);

    run_frame(0);   // flat grey
    run_frame(1);   // vertical step
    run_frame(2);   // step to gray 25: magnitude exactly at threshold
    run_frame(3);   // step to gray 24: just under threshold
    run_frame(4);   // random content

    // Step frame interrupted by reset while row 3 is still in the pipeline
    fill(1);
    vsync_pulse();
    for (int y = 0; y < 4; y++) send_line(y, y);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n   = 1'b1;
    sync_ok = cyc + 6;
    for (int y = 4; y < TB_V; y++) send_line(y, y - 4);
    idle(3);

    // Next frame after the reset must be fully correct again
    run_frame(1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
